// File: rtl/jtcps1_palcpy_if.sv
// VRAM read port and palette RAM write port of the palette copy engine.
// master = copy engine, slave = VRAM arbiter / palette RAM side.
interface jtcps1_palcpy_if;
    logic [16:0] vram_addr;
    logic        vram_req;
    logic        vram_ok;
    logic [15:0] vram_data;
    logic [11:0] pal_addr;
    logic [15:0] pal_data;
    logic        pal_we;

    modport master (
        output vram_addr, vram_req, pal_addr, pal_data, pal_we,
        input  vram_ok, vram_data
    );
    modport slave (
        input  vram_addr, vram_req, pal_addr, pal_data, pal_we,
        output vram_ok, vram_data
    );
endinterface

// File: rtl/jtcps1_palcpy.sv
// CPS-A palette copy engine: walks enabled palette pages, reading words
// contiguously from VRAM and writing them one per cycle into palette RAM.
module jtcps1_palcpy #(
    parameter int PAGES = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pal_copy,
    input  logic [15:0] pal_base,
    input  logic [ 5:0] pal_page_en,
    output logic        busy,
    output logic        done,
    jtcps1_palcpy_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0,
                           SCAN  = 3'd1,
                           READ  = 3'd2,
                           WRITE = 3'd3,
                           FIN   = 3'd4;
    localparam logic [2:0] END_PAGE = 3'(PAGES);

    logic [ 2:0] st, page;
    logic [ 9:0] cur_base, pend_base;
    logic [ 5:0] cur_en, pend_en;
    logic        pending;
    logic [ 8:0] entry;
    logic [11:0] src_off, src_nxt;
    logic [ 7:0] en_ext;
    logic [16:0] base_addr;

    // only the low 10 bits of the base select the VRAM window
    wire unused_base = ^pal_base[15:10];

    assign en_ext    = {2'b0, cur_en};
    assign src_nxt   = src_off + 12'd1;
    assign base_addr = {cur_base, 7'd0};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st            <= IDLE;
            page          <= 3'd0;
            entry         <= 9'd0;
            src_off       <= 12'd0;
            cur_base      <= 10'd0;
            cur_en        <= 6'd0;
            pend_base     <= 10'd0;
            pend_en       <= 6'd0;
            pending       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.vram_req  <= 1'b0;
            bus.vram_addr <= 17'd0;
            bus.pal_we    <= 1'b0;
            bus.pal_addr  <= 12'd0;
            bus.pal_data  <= 16'd0;
        end else begin
            bus.pal_we <= 1'b0;
            done       <= 1'b0;
            // requests arriving mid-copy queue up; the newest one wins
            if (pal_copy && st != IDLE && st != FIN) begin
                pending   <= 1'b1;
                pend_base <= pal_base[9:0];
                pend_en   <= pal_page_en;
            end
            case (st)
                IDLE: if (pal_copy) begin
                    cur_base <= pal_base[9:0];
                    cur_en   <= pal_page_en;
                    page     <= 3'd0;
                    entry    <= 9'd0;
                    src_off  <= 12'd0;
                    busy     <= 1'b1;
                    st       <= SCAN;
                end
                SCAN: begin
                    if (page == END_PAGE) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        st   <= FIN;
                    end else if (en_ext[page]) begin
                        bus.vram_req  <= 1'b1;
                        bus.vram_addr <= base_addr + {5'd0, src_off};
                        st            <= READ;
                    end else begin
                        page <= page + 3'd1;
                    end
                end
                READ: if (bus.vram_ok) begin
                    bus.pal_data <= bus.vram_data;
                    bus.pal_addr <= {page, entry};
                    bus.pal_we   <= 1'b1;
                    bus.vram_req <= 1'b0;
                    st           <= WRITE;
                end
                WRITE: begin
                    src_off <= src_nxt;
                    if (entry == 9'd511) begin
                        entry <= 9'd0;
                        page  <= page + 3'd1;
                        st    <= SCAN;
                    end else begin
                        entry         <= entry + 9'd1;
                        bus.vram_req  <= 1'b1;
                        bus.vram_addr <= base_addr + {5'd0, src_nxt};
                        st            <= READ;
                    end
                end
                FIN: begin
                    // a request landing on this very cycle takes priority over the stored one
                    if (pal_copy || pending) begin
                        cur_base <= pal_copy ? pal_base[9:0] : pend_base;
                        cur_en   <= pal_copy ? pal_page_en   : pend_en;
                        pending  <= 1'b0;
                        page     <= 3'd0;
                        entry    <= 9'd0;
                        src_off  <= 12'd0;
                        busy     <= 1'b1;
                        st       <= SCAN;
                    end else begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtcps1_palcpy.sv
// Bench for jtcps1_palcpy: VRAM responder, expected-write queue model and
// per-cycle compare process, plus directed scenarios with literal anchors.
module tb_jtcps1_palcpy;
    logic        clk = 1'b0, rstn = 1'b1, pal_copy = 1'b0;
    logic [15:0] pal_base = '0;
    logic [ 5:0] pal_page_en = '0;
    logic        busy, done;

    jtcps1_palcpy_if bus();

    jtcps1_palcpy #(.PAGES(6)) dut (
        .clk(clk), .rstn(rstn), .pal_copy(pal_copy), .pal_base(pal_base),
        .pal_page_en(pal_page_en), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [16:0] src; logic [11:0] pa; logic [15:0] pd; } exp_t;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [16:0] rd_log[$];
    logic [11:0] wa_log[$];
    logic [15:0] wd_log[$];
    int vectors = 0, miscompares = 0, ndone = 0, nok = 0, nwr = 0;
    int dly_fix = 0;
    bit dly_rand = 1'b0;

    function automatic logic [15:0] vmem(input logic [16:0] a);
        return a[15:0] ^ {a[16], a[16:2]} ^ 16'h3c5a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected palette writes for one copy: enabled pages in order, sources packed from base.
    task automatic push_copy(input logic [15:0] base, input logic [5:0] en);
        exp_t e;
        int k = 0;
        for (int p = 0; p < 6; p++)
            if (en[p])
                for (int n = 0; n < 512; n++) begin
                    e.src = {base[9:0], 7'd0} + 17'(k);
                    e.pa  = 12'(p * 512 + n);
                    e.pd  = vmem(e.src);
                    exp_q.push_back(e);
                    k++;
                end
    endtask

    task automatic clear_logs();
        rd_log.delete(); wa_log.delete(); wd_log.delete();
        nwr = 0; nok = 0; ndone = 0;
    endtask

    // VRAM side: acknowledge each request after a fixed or random wait.
    initial begin
        int  wait_cnt = 0;
        bit  seen = 1'b0;
        bus.vram_ok   = 1'b0;
        bus.vram_data = '0;
        forever begin
            @(posedge clk); #1;
            bus.vram_ok = 1'b0;
            if (rstn && bus.vram_req) begin
                if (!seen) begin
                    seen = 1'b1;
                    wait_cnt = dly_rand ? int'($urandom_range(7, 0)) : dly_fix;
                end
                if (wait_cnt == 0) begin
                    bus.vram_ok   = 1'b1;
                    bus.vram_data = vmem(bus.vram_addr);
                    seen = 1'b0;
                end else wait_cnt--;
            end else seen = 1'b0;
        end
    end

    // Compare process
    logic        prev_req = 1'b0, prev_ok = 1'b0;
    logic [16:0] prev_addr = '0;
    always @(negedge clk) begin
        if (rstn) begin
            if (prev_req && !prev_ok) begin
                chk("req_hold", bus.vram_req, 1);
                chk("addr_hold", bus.vram_addr, prev_addr);
            end
            if (bus.pal_we) begin
                nwr++;
                wa_log.push_back(bus.pal_addr);
                wd_log.push_back(bus.pal_data);
                chk("req_low_at_we", bus.vram_req, 0);
                if (exp_q.size() == 0) chk("spurious_we", bus.pal_we, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("pal_addr", bus.pal_addr, mon_e.pa);
                    chk("pal_data", bus.pal_data, mon_e.pd);
                end
            end
            if (bus.vram_req) begin
                if (exp_q.size() == 0) chk("spurious_req", bus.vram_req, 0);
                else chk("vram_addr", bus.vram_addr, exp_q[0].src);
                if (bus.vram_ok) begin
                    nok++;
                    rd_log.push_back(bus.vram_addr);
                end
            end
            if (done) begin
                ndone++;
                chk("busy_at_done", busy, 0);
            end
        end
        prev_req  = rstn && bus.vram_req;
        prev_ok   = bus.vram_ok;
        prev_addr = bus.vram_addr;
    end

    task automatic pulse(input logic [15:0] b, input logic [5:0] en);
        @(negedge clk);
        pal_copy = 1'b1; pal_base = b; pal_page_en = en;
        @(negedge clk);
        pal_copy = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!done && i < budget) begin @(negedge clk); i++; end
        if (!done) chk("done_timeout", done, 1);
        else @(negedge clk);
    endtask

    initial begin
        int g;
        #1 rstn = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);          chk("rst_done", done, 0);
        chk("rst_req", bus.vram_req, 0);   chk("rst_addr", bus.vram_addr, 0);
        chk("rst_we", bus.pal_we, 0);      chk("rst_pa", bus.pal_addr, 0);
        chk("rst_pd", bus.pal_data, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // full six-page copy, zero-wait acknowledge
        clear_logs();
        pulse(16'h0090, 6'h3f); push_copy(16'h0090, 6'h3f);
        chk("t1_busy_c1", busy, 1);
        chk("t1_req_c1", bus.vram_req, 0);
        @(negedge clk);
        chk("t1_req_c2", bus.vram_req, 1);
        chk("t1_addr_c2", bus.vram_addr, 17'h04800);
        wait_done(8000);
        chk("t1_writes", nwr, 3072);
        chk("t1_ok_eq_we", nok, nwr);
        chk("t1_done_cnt", ndone, 1);
        chk("t1_exp_left", exp_q.size(), 0);
        if (rd_log.size() == 3072) begin
            chk("t1_first_rd", rd_log[0], 17'h04800);
            chk("t1_last_rd", rd_log[3071], 17'h053ff);
            chk("t1_last_pa", wa_log[3071], 12'hbff);
            chk("t1_first_pd", wd_log[0], 16'h665a);
        end

        // no pages enabled: only skip cycles, done at cycle 8
        clear_logs();
        pulse(16'h0090, 6'h00);
        repeat (6) @(negedge clk);
        chk("en0_busy_c7", busy, 1);
        chk("en0_done_c7", done, 0);
        @(negedge clk);
        chk("en0_done_c8", done, 1);
        chk("en0_busy_c8", busy, 0);
        @(negedge clk);
        chk("en0_done_c9", done, 0);
        chk("en0_writes", nwr, 0);
        chk("en0_reads", nok, 0);

        // pages 0 and 2, source packed
        clear_logs();
        pulse(16'h0090, 6'b000101); push_copy(16'h0090, 6'b000101);
        wait_done(3000);
        chk("p02_writes", nwr, 1024);
        if (rd_log.size() == 1024) begin
            chk("p02_rd512", rd_log[512], 17'h04a00);
            chk("p02_pa511", wa_log[511], 12'h1ff);
            chk("p02_pa512", wa_log[512], 12'h400);
        end

        // random acknowledge latency
        clear_logs();
        dly_rand = 1'b1;
        pulse(16'h0123, 6'b000010); push_copy(16'h0123, 6'b000010);
        wait_done(6000);
        dly_rand = 1'b0;
        chk("rnd_writes", nwr, 512);
        chk("rnd_ok_eq_we", nok, nwr);
        if (rd_log.size() == 512) begin
            chk("rnd_first_rd", rd_log[0], 17'h09180);
            chk("rnd_first_pa", wa_log[0], 12'h200);
        end

        // second request mid-copy runs after the first without a new pulse
        clear_logs();
        pulse(16'h0090, 6'b000001); push_copy(16'h0090, 6'b000001);
        repeat (100) @(negedge clk);
        pulse(16'h00a0, 6'b000011); push_copy(16'h00a0, 6'b000011);
        wait_done(3000);
        chk("pend_first_done", ndone, 1);
        chk("pend_relaunch_busy", busy, 1);
        chk("pend_first_reads", rd_log.size(), 512);
        if (rd_log.size() == 512) chk("pend_first_last", rd_log[511], 17'h049ff);
        clear_logs();
        wait_done(4000);
        chk("pend_second_writes", nwr, 1024);
        chk("pend_second_done", ndone, 1);
        if (rd_log.size() == 1024) begin
            chk("pend_second_first", rd_log[0], 17'h05000);
            chk("pend_second_last", rd_log[1023], 17'h053ff);
            chk("pend_second_pa512", wa_log[512], 12'h200);
        end

        // reset while a read is waiting for its acknowledge
        clear_logs();
        dly_fix = 5;
        pulse(16'h0090, 6'h3f); push_copy(16'h0090, 6'h3f);
        g = 0;
        while (nwr < 3 && g < 200) begin @(negedge clk); g++; end
        while (!(bus.vram_req && !bus.vram_ok) && g < 400) begin @(negedge clk); g++; end
        chk("rst_setup_req", bus.vram_req, 1);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_req", bus.vram_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_we", bus.pal_we, 0);
        chk("abort_addr", bus.vram_addr, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        dly_fix = 0;
        clear_logs();
        pulse(16'h00a0, 6'b000001); push_copy(16'h00a0, 6'b000001);
        wait_done(1500);
        chk("post_rst_writes", nwr, 512);
        chk("post_rst_done", ndone, 1);
        if (rd_log.size() == 512) begin
            chk("post_rst_first_rd", rd_log[0], 17'h05000);
            chk("post_rst_first_pa", wa_log[0], 12'h000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/jtcps1_palcpy.md
# jtcps1_palcpy

Palette copy engine for the CPS-A video path. On each palette-copy request from the register block (`pal_copy` pulse with `pal_base` and `pal_page_en`), it reads palette words from VRAM through a request/acknowledge port and writes them into the internal palette RAM consumed by the colour mixer. It sits directly downstream of the MMR block and upstream of the palette RAM and colmix stages.

## Interface
Parameters:
- PAGES, 6, number of palette pages scanned (1..6); page index width is 3 bits regardless.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous, active-low reset
- pal_copy  in  1  one-cycle start pulse from MMR
- pal_base  in  16  palette source base; word address = {pal_base[9:0], 7'd0}
- pal_page_en  in  6  bit p set = copy page p
- busy  out  1  copy in progress
- done  out  1  one-cycle pulse at copy end
- vram_addr  out  17  VRAM word address [17:1]
- vram_req  out  1  read request, held until vram_ok
- vram_ok  in  1  one-cycle acknowledge; vram_data valid same cycle
- vram_data  in  16  read data
- pal_addr  out  12  palette RAM address {page[2:0], entry[8:0]}
- pal_data  out  16  palette RAM write data
- pal_we  out  1  palette RAM write strobe, one cycle per word

## Operation
- Reset: all outputs 0 (busy, done, vram_req, vram_addr, pal_we, pal_addr, pal_data); state IDLE; pending flag clear.
- Registered copies: cur_base, cur_en, page (3 b), entry (9 b), src_off (12 b).
- States:
  - IDLE: on pal_copy, latch pal_base/pal_page_en, page=0, entry=0, src_off=0, busy=1, go SCAN.
  - SCAN: if page==PAGES go FIN; else if cur_en[page] go READ; else page++, stay in SCAN (one cycle per skipped page; src_off is not advanced).
  - READ: vram_req=1, vram_addr={cur_base[9:0],7'd0}+src_off (17-bit wrap); hold both stable until vram_ok. On vram_ok: pal_data<=vram_data, pal_addr<={page,entry}, vram_req<=0, go WRITE.
  - WRITE: pal_we=1 for exactly this cycle; src_off++; if entry==511 then entry=0, page++, go SCAN; else entry++, go READ.
  - FIN: done=1 for one cycle, busy=0; if pending, relaunch as in IDLE with stored values (busy re-asserted the next cycle), else go IDLE.
- Source packing: enabled pages read contiguously from base; disabled pages consume neither source words nor destination writes (destination page index is still page).
- pal_copy while busy: store pal_base/pal_page_en into pending registers and set pending (later request overwrites earlier); current copy completes unchanged.
- pal_copy in the same cycle as FIN: treated as pending, relaunched immediately.
- pal_page_en==0: IDLE→SCAN→(PAGES skip cycles)→FIN; done pulses, no VRAM or RAM access.
- rstn low mid-copy: immediate abort, all outputs to reset values, pending lost.

## Timing
- pal_copy at cycle 0 → busy=1 at cycle 1; with page 0 enabled, vram_req=1 with valid address at cycle 2.
- vram_ok at cycle n → pal_we=1 at n+1 (vram_req=0), next vram_req at n+2.
- Per word minimum 2 cycles with zero-wait acknowledge; full 6-page copy = 6×512×2 + overhead cycles.
- vram_addr changes only when vram_req is low.
- done rises the cycle after the last WRITE plus one SCAN cycle; busy falls with done.

## Test plan
- pal_base=16'h0090, en=6'h3f, ok one cycle after each req → 3072 pal_we; first vram_addr=17'h4800, last=17'h53ff; pal_addr 0..3071 in order; data matches VRAM model.
- en=6'b000101 → pages 0 and 2 written; page-2 entry 0 reads src_off 512 (vram_addr base+512); exactly 1024 writes; pal_addr never in page 1.
- vram_ok delayed 0..7 random cycles → vram_addr/vram_req stable while waiting; exactly one pal_we per ok.
- Second pal_copy (base 16'h00a0) mid-copy → first copy finishes at original base, done pulses, second starts at 17'h5000 without a new pulse.
- en=0 → done pulse after PAGES+2 cycles, no vram_req, no pal_we.
- rstn pulsed low mid-READ → vram_req, busy, pal_we zero immediately; a new pal_copy after release starts from page 0.
